// File: rtl/mcpu5_pkg.sv
// mcpu5_pkg: shared types and constants for the MCPU5 program sequencer.
package mcpu5_pkg;

  localparam int INST_W = 6;

  // OUT opcode; it doubles as the idle/no-op instruction fed to the core.
  localparam logic [INST_W-1:0] MCPU5_OP_OUT = 6'b111001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CPURST = 2'b01,
    ST_RUN    = 2'b10,
    ST_DONE   = 2'b11
  } seq_state_t;

  typedef enum logic [1:0] {
    HALT_LIMIT    = 2'b00,
    HALT_PAST_END = 2'b01,
    HALT_ABORT    = 2'b10,
    HALT_EMPTY    = 2'b11
  } halt_reason_t;

endpackage

// File: rtl/mcpu5_imem.sv
// mcpu5_imem: DEPTH x INST_W instruction register file.
// One synchronous write port (program loading), one asynchronous read port
// so the core's PC selects its instruction in the same cycle.
module mcpu5_imem
  import mcpu5_pkg::*;
#(
  parameter int  DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [INST_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [INST_W-1:0] rdata_o
);

  logic [INST_W-1:0] mem_q [DEPTH];

  // Write one program word per cycle.
  // NOTE: the array has no reset -- only words below prog_len are ever
  // fetched, so stale contents are harmless and the storage stays a plain
  // register file. State updates use non-blocking assignments so every
  // register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mcpu5_sequencer.sv
// mcpu5_sequencer: program store and run controller for the MCPU5 core.
// Loads a program over valid/ready, holds the core in reset for RST_CYCLES,
// then feeds mem[PC] each cycle until a limit, fetch past end or abort.
// Optional feature: define MCPU5_SEQ_OUTCAP_EN to add OUT-data capture
// (data_out / data_valid ports).
module mcpu5_sequencer
  import mcpu5_pkg::*;
#(
  parameter int                DEPTH      = 32,
  parameter int                RST_CYCLES = 2,
  parameter logic [INST_W-1:0] NOP_INST   = MCPU5_OP_OUT,
  localparam int               AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [INST_W-1:0] load_data,
  output logic              load_ready,
  input  logic              load_clear,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       cycle_limit,
  input  logic [7:0]        cpu_out,
  output logic [INST_W-1:0] cpu_inst,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic [1:0]        halt_reason,
  output logic [15:0]       run_cycles,
  output logic [AW:0]       prog_len
`ifdef MCPU5_SEQ_OUTCAP_EN
  ,
  output logic [7:0]        data_out,
  output logic              data_valid
`endif
);

  localparam int            CW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [AW:0]   FULL_LEN = (AW + 1)'(DEPTH);

  seq_state_t        state_q;
  halt_reason_t      halt_q;
  logic [AW:0]       prog_len_q, prog_len_d;
  logic [15:0]       run_cycles_q, run_cycles_inc;
  logic [CW-1:0]     rst_cnt_q;
  logic              cpu_reset_q, busy_q, done_q;

  logic              load_phase, load_fire, clear_fire, mem_we;
  logic              in_run, data_cyc, fetch_cyc, past_end, limit_hit, run_exit;
  logic [AW-1:0]     rd_addr;
  logic [INST_W-1:0] rd_data;

  // ---------------------------------------------------------------------
  // Program loading: only while the core is parked (IDLE / DONE).
  // A clear wins over a same-cycle write, so that word is discarded.
  // ---------------------------------------------------------------------
  assign load_phase = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign load_ready = load_phase && (prog_len_q != FULL_LEN);
  assign load_fire  = load_valid && load_ready;
  assign clear_fire = load_phase && load_clear;
  assign mem_we     = load_fire && !clear_fire;
  assign prog_len_d = clear_fire ? '0
                    : mem_we     ? prog_len_q + (AW + 1)'(1)
                    :              prog_len_q;

  // ---------------------------------------------------------------------
  // Run-time decode. In a data cycle (output capture only) cpu_out carries
  // data, not a PC, so the past-end check is skipped for that cycle.
  // ---------------------------------------------------------------------
  assign in_run    = (state_q == ST_RUN);
  assign fetch_cyc = in_run && !data_cyc;
  assign past_end  = fetch_cyc && ({1'b0, cpu_out} >= 9'(prog_len_q));
  assign limit_hit = (cycle_limit != 16'd0) &&
                     (({1'b0, run_cycles_q} + 17'd1) == {1'b0, cycle_limit});
  assign run_exit  = abort || past_end || limit_hit;

  assign run_cycles_inc = (run_cycles_q == 16'hFFFF) ? run_cycles_q
                                                     : run_cycles_q + 16'd1;

  assign cpu_inst = (in_run && !past_end) ? rd_data : NOP_INST;

  mcpu5_imem #(
    .DEPTH (DEPTH)
  ) u_imem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (prog_len_q[AW-1:0]),
    .wdata_i (load_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

`ifdef MCPU5_SEQ_OUTCAP_EN
  logic          data_cyc_q, data_valid_q;
  logic [7:0]    data_out_q;
  logic [AW-1:0] last_pc_q;

  // An OUT fetched in RUN makes the next cycle a data cycle; latch the data.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_cyc_q   <= 1'b0;
      data_valid_q <= 1'b0;
      data_out_q   <= 8'h00;
      last_pc_q    <= '0;
    end else begin
      data_cyc_q   <= fetch_cyc && !run_exit && (cpu_inst == NOP_INST);
      data_valid_q <= in_run && data_cyc_q;
      if (fetch_cyc) begin
        last_pc_q <= cpu_out[AW-1:0];
      end
      if (in_run && data_cyc_q) begin
        data_out_q <= cpu_out;
      end
    end
  end

  assign data_cyc   = data_cyc_q;
  assign rd_addr    = data_cyc_q ? last_pc_q + AW'(1) : cpu_out[AW-1:0];
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
`else
  assign data_cyc = 1'b0;
  assign rd_addr  = cpu_out[AW-1:0];
`endif

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      halt_q       <= HALT_LIMIT;
      prog_len_q   <= '0;
      run_cycles_q <= 16'd0;
      rst_cnt_q    <= '0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      prog_len_q <= prog_len_d;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          // prog_len_d so that a load in the start cycle counts.
          if (start) begin
            if (prog_len_d == '0) begin
              state_q     <= ST_DONE;
              halt_q      <= HALT_EMPTY;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              cpu_reset_q <= 1'b1;
            end else begin
              state_q      <= ST_CPURST;
              run_cycles_q <= 16'd0;
              rst_cnt_q    <= '0;
              done_q       <= 1'b0;
              busy_q       <= 1'b1;
              cpu_reset_q  <= 1'b1;
            end
          end
        end
        ST_CPURST: begin
          if (abort) begin
            state_q <= ST_DONE;
            halt_q  <= HALT_ABORT;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (rst_cnt_q == RST_LAST) begin
            state_q     <= ST_RUN;
            cpu_reset_q <= 1'b0;
          end else begin
            rst_cnt_q <= rst_cnt_q + CW'(1);
          end
        end
        ST_RUN: begin
          run_cycles_q <= run_cycles_inc;
          if (run_exit) begin
            state_q     <= ST_DONE;
            halt_q      <= abort    ? HALT_ABORT
                         : past_end ? HALT_PAST_END
                         :            HALT_LIMIT;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            cpu_reset_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu_reset   = cpu_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign halt_reason = halt_q;
  assign run_cycles  = run_cycles_q;
  assign prog_len    = prog_len_q;

endmodule
